matrix_op_sequencer: RTL and testbench
======================================

Name: matrix_op_sequencer

Overview:
- Controller for the 5x5 signed-8-bit matrix coprocessor.
- Accepts one operation request over a start/busy/done handshake and latches operands A and B.
- Processes element-wise ops (add, sub, opposite, scalar multiply, transpose) one row of LANES elements per cycle through a shared lane datapath.
- Presents the 200-bit result plus status flags; sits between the command decoder and the result register bank.

Parameters:
- LANES, 5, elements processed per EXEC cycle; legal values 1, 5, 25 (must divide 25).
- DIM, 5, matrix dimension; fixed at 5, present for readability only.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse/level; sampled only in IDLE
- opcode  input  3  000 add, 001 sub (A-B), 010 opposite(A), 011 transpose(A), 100 scalar k*A, 101-111 invalid
- scalar_k  input  8  signed scalar for opcode 100
- matrix_A  input  200  signed, element i at [8i+:8], i = row*5+col
- matrix_B  input  200  signed, same layout
- busy  output  1  high from the cycle after accept until done
- done  output  1  one-cycle pulse when result is valid
- result  output  200  signed result, same layout; held until the next accept
- overflow  output  1  sticky per operation: any element overflowed or clipped
- op_error  output  1  invalid opcode seen; valid with done

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, result=0, overflow=0, op_error=0, element counter=0. Reset mid-operation aborts immediately; no done pulse is produced.
- FSM states: IDLE, LOAD, EXEC, FINISH.
- IDLE, start=1: latch A, B, opcode, scalar_k; clear overflow and op_error; go to LOAD. start is ignored in every other state.
- LOAD: busy=1. Invalid opcode sets op_error=1, leaves result unchanged, then goes to FINISH. Otherwise idx=0, go to EXEC.
- EXEC: busy=1. Each cycle computes elements idx..idx+LANES-1 and writes them into result; idx += LANES. After 25/LANES cycles, go to FINISH.
- FINISH: done=1 and busy=0 for exactly one cycle, then IDLE. start asserted in the FINISH cycle is not accepted; it is accepted on the following IDLE cycle.
- Latency: start high in IDLE at edge N gives done at edge N+2+25/LANES. Default 7 cycles; invalid opcode 2 cycles.
- Arithmetic: widen operands to 10 bits (16 bits for multiply), compute, then reduce to 8 bits. An element overflows if the true result is outside [-128, 127].
- Opposite: -a. The value -128 overflows.
- Transpose: result[r*5+c] = A[c*5+r]. Never overflows.
- Element results not yet written during EXEC keep their previous values. result must be read only at or after done.
- Inputs may change after accept without affecting the running operation.

Optional Feature:
- Macro: MATRIX_SATURATION_EN.
- Defined: overflowing elements clamp to 127 or -128, and overflow=1.
- Undefined: overflowing elements wrap (two's-complement truncation to 8 bits), and overflow=1.
- Non-overflowing results are identical in both builds.

Test Plan:
- Add, LANES=5: A all 10, B all 20, start one cycle -> busy for 6 cycles, done at cycle 7 after accept edge, all elements 30, overflow=0, op_error=0.
- Opposite: A element 0 = -128, element 1 = 5, others 0 -> element 1 = -5, overflow=1; element 0 = 127 with MATRIX_SATURATION_EN, -128 without.
- Transpose: A[i]=i (0..24) -> result[r*5+c] = c*5+r, e.g. result[1]=5, result[5]=1, result[24]=24; overflow=0.
- Scalar multiply: k=-3, A element 0=50, element 1=-40 -> element 0 = -128 (sat) or 106 (wrap), element 1 = 120; overflow=1.
- Invalid opcode 110 -> done 2 cycles after accept, op_error=1, result equal to its previous value.
- rst_n low during EXEC cycle 3 -> next cycle busy=0, result=0, no done pulse; a new start then completes normally. start held high through FINISH -> a second operation begins on the following IDLE cycle.

Source files
------------

// File: rtl/matrix_op_sequencer.sv
// Sequencer for the 5x5 signed 8-bit matrix coprocessor: start/busy/done handshake, LANES elements
// per EXEC cycle. Define MATRIX_SATURATION_EN to clamp overflowing elements instead of wrapping.
module matrix_op_sequencer #(
  parameter int unsigned LANES = 5,
  parameter int unsigned DIM   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   opcode,
  input  logic [7:0]   scalar_k,
  input  logic [199:0] matrix_A,
  input  logic [199:0] matrix_B,
  output logic         busy,
  output logic         done,
  output logic [199:0] result,
  output logic         overflow,
  output logic         op_error
);

  localparam int unsigned NumElem = DIM * DIM;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StExec   = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpSub   = 3'b001;
  localparam logic [2:0] OpNeg   = 3'b010;
  localparam logic [2:0] OpTrn   = 3'b011;
  localparam logic [2:0] OpScale = 3'b100;

  logic [1:0]   state_q, state_d;
  logic [199:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]   op_q, op_d;
  logic [7:0]   k_q, k_d;
  logic [4:0]   idx_q, idx_d;
  logic         ovf_q, ovf_d, err_q, err_d;

  logic [199:0] exec_res;
  logic         exec_ovf;
  logic         exec_last;
  int unsigned  elem_idx, src_idx;
  logic [8:0]   lane_out;

  // Returns {overflow, value} for one element; t is the transposed source element.
  function automatic logic [8:0] calc_elem(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] k,
                                           input logic [7:0] t);
    logic signed [9:0]  a10, b10, s10;
    logic signed [15:0] wide;
    logic               ovf;
    logic [7:0]         res;
    a10 = {{2{a[7]}}, a};
    b10 = {{2{b[7]}}, b};
    s10 = '0;
    case (op)
      OpAdd:   s10 = a10 + b10;
      OpSub:   s10 = a10 - b10;
      OpNeg:   s10 = -a10;
      default: s10 = '0;
    endcase
    if (op == OpScale) wide = {{8{a[7]}}, a} * {{8{k[7]}}, k};
    else               wide = {{6{s10[9]}}, s10};
    ovf = (wide > 16'sd127) || (wide < -16'sd128);
`ifdef MATRIX_SATURATION_EN
    res = ovf ? (wide[15] ? 8'h80 : 8'h7f) : wide[7:0];
`else
    res = wide[7:0];
`endif
    if (op == OpTrn) return {1'b0, t};
    return {ovf, res};
  endfunction

  always_comb begin
    exec_res = result_q;
    exec_ovf = 1'b0;
    elem_idx = 0;
    src_idx  = 0;
    lane_out = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      elem_idx = 32'(idx_q) + l;
      if (elem_idx < NumElem) begin
        src_idx  = (elem_idx % DIM) * DIM + elem_idx / DIM;
        lane_out = calc_elem(op_q, a_q[8*elem_idx +: 8], b_q[8*elem_idx +: 8], k_q,
                             a_q[8*src_idx +: 8]);
        exec_res[8*elem_idx +: 8] = lane_out[7:0];
        exec_ovf = exec_ovf | lane_out[8];
      end
    end
  end

  assign exec_last = (32'(idx_q) + LANES) >= NumElem;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    k_d      = k_q;
    idx_d    = idx_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = matrix_A;
          b_d     = matrix_B;
          op_d    = opcode;
          k_d     = scalar_k;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (op_q > OpScale) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          idx_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = exec_res;
        ovf_d    = ovf_q | exec_ovf;
        idx_d    = idx_q + 5'(LANES);
        if (exec_last) state_d = StFinish;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign busy     = (state_q == StLoad) || (state_q == StExec);
  assign done     = (state_q == StFinish);
  assign result   = result_q;
  assign overflow = ovf_q;
  assign op_error = err_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer: a scoreboard of expected results is filled at each
// accepted start and drained at each done pulse.
module tb_matrix_op_sequencer;

  localparam int Lanes   = 5;
  localparam int ExecLat = 2 + 25 / Lanes;
  localparam int ErrLat  = 2;

  typedef struct {
    logic [199:0] res;
    logic         ovf;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   opcode = '0;
  logic [7:0]   scalar_k = '0;
  logic [199:0] matrix_A = '0;
  logic [199:0] matrix_B = '0;
  logic         busy, done, overflow, op_error;
  logic [199:0] result;

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [199:0] exp_prev = '0;
  exp_t         sb[$];

  matrix_op_sequencer #(.LANES(Lanes), .DIM(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .scalar_k (scalar_k),
    .matrix_A (matrix_A),
    .matrix_B (matrix_B),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .op_error (op_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] fill(input logic [7:0] v);
    logic [199:0] r;
    for (int i = 0; i < 25; i++) r[8*i +: 8] = v;
    return r;
  endfunction

  function automatic logic [199:0] rand_mat();
    logic [199:0] r;
    for (int i = 0; i < 25; i++) r[8*i +: 8] = 8'($urandom);
    return r;
  endfunction

  // Reference behaviour computed with plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [7:0] k, input logic [199:0] a,
                       input logic [199:0] b, output exp_t x);
    int va, vb, vk, v;
    x.res = exp_prev;
    x.ovf = 1'b0;
    x.err = 1'b0;
    if (op > 3'd4) begin
      x.err = 1'b1;
      return;
    end
    vk = $signed(k);
    for (int i = 0; i < 25; i++) begin
      if (op == 3'd3) begin
        x.res[8*i +: 8] = a[8*((i % 5) * 5 + i / 5) +: 8];
      end else begin
        va = $signed(a[8*i +: 8]);
        vb = $signed(b[8*i +: 8]);
        case (op)
          3'd0:    v = va + vb;
          3'd1:    v = va - vb;
          3'd2:    v = -va;
          default: v = va * vk;
        endcase
        if (v > 127 || v < -128) begin
          x.ovf = 1'b1;
`ifdef MATRIX_SATURATION_EN
          v = (v > 127) ? 127 : -128;
`endif
        end
        x.res[8*i +: 8] = v[7:0];
      end
    end
  endtask

  // Drives start in an IDLE cycle and returns just after the accepting edge.
  task automatic launch(input logic [2:0] op, input logic [7:0] k, input logic [199:0] a,
                        input logic [199:0] b);
    exp_t x;
    @(negedge clk);
    opcode   = op;
    scalar_k = k;
    matrix_A = a;
    matrix_B = b;
    start    = 1'b1;
    model(op, k, a, b, x);
    sb.push_back(x);
    exp_prev = x.res;
    @(posedge clk);
  endtask

  task automatic wait_done(input bit hold, input int lat);
    int   cnt, nbusy;
    bit   got;
    exp_t x;
    cnt   = 0;
    nbusy = 0;
    got   = 1'b0;
    while (cnt < 50 && !got) begin
      @(negedge clk);
      cnt++;
      if (!hold && cnt == 1) begin
        start    = 1'b0;
        matrix_A = rand_mat();
        matrix_B = rand_mat();
        opcode   = 3'($urandom);
        scalar_k = 8'($urandom);
      end
      if (done) got = 1'b1;
      else if (busy) nbusy++;
    end
    check_i("done_seen", int'(got), 1);
    check_i("latency", cnt, lat);
    check_i("busy_cycles", nbusy, lat - 1);
    check("busy_at_done", 200'(busy), 200'(0));
    check_i("sb_nonempty", sb.size(), 1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      check("result", result, x.res);
      check("overflow", 200'(overflow), 200'(x.ovf));
      check("op_error", 200'(op_error), 200'(x.err));
    end
  endtask

  initial begin
    logic [199:0] m;
    int ndone;

    repeat (3) @(negedge clk);
    check("rst_busy", 200'(busy), 200'(0));
    check("rst_done", 200'(done), 200'(0));
    check("rst_result", result, 200'(0));
    check("rst_ovf", 200'(overflow), 200'(0));
    check("rst_err", 200'(op_error), 200'(0));
    rst_n = 1'b1;

    launch(3'b000, 8'd0, fill(8'd10), fill(8'd20));
    wait_done(1'b0, ExecLat);
    check("add_all30", result, fill(8'd30));

    m = '0;
    m[7:0]  = 8'h80;
    m[15:8] = 8'd5;
    launch(3'b010, 8'd0, m, rand_mat());
    wait_done(1'b0, ExecLat);
    check("neg_e1", 200'(result[15:8]), 200'(8'hfb));
`ifdef MATRIX_SATURATION_EN
    check("neg_e0", 200'(result[7:0]), 200'(8'h7f));
`else
    check("neg_e0", 200'(result[7:0]), 200'(8'h80));
`endif

    for (int i = 0; i < 25; i++) m[8*i +: 8] = 8'(i);
    launch(3'b011, 8'd0, m, rand_mat());
    wait_done(1'b0, ExecLat);
    check("trn_r1", 200'(result[15:8]), 200'(8'd5));
    check("trn_r5", 200'(result[47:40]), 200'(8'd1));
    check("trn_r24", 200'(result[199:192]), 200'(8'd24));

    launch(3'b001, 8'd0, rand_mat(), rand_mat());
    wait_done(1'b0, ExecLat);

    m = '0;
    m[7:0]  = 8'd50;
    m[15:8] = 8'hd8;
    launch(3'b100, 8'hfd, m, rand_mat());
    wait_done(1'b0, ExecLat);
    check("scl_e1", 200'(result[15:8]), 200'(8'd120));

    launch(3'b110, 8'd7, rand_mat(), rand_mat());
    wait_done(1'b0, ErrLat);

    // Abort during the third EXEC cycle.
    launch(3'b000, 8'd0, rand_mat(), rand_mat());
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 200'(busy), 200'(0));
    check("abort_done", 200'(done), 200'(0));
    check("abort_result", result, 200'(0));
    if (sb.size() != 0) void'(sb.pop_front());
    exp_prev = '0;
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_i("abort_no_done", ndone, 0);

    launch(3'b001, 8'd0, rand_mat(), rand_mat());
    wait_done(1'b0, ExecLat);

    // start held through FINISH: re-accepted on the following IDLE cycle.
    launch(3'b000, 8'd0, rand_mat(), rand_mat());
    wait_done(1'b1, ExecLat);
    begin
      exp_t x;
      @(negedge clk);
      check("held_idle_busy", 200'(busy), 200'(0));
      check("held_idle_done", 200'(done), 200'(0));
      model(opcode, scalar_k, matrix_A, matrix_B, x);
      sb.push_back(x);
      exp_prev = x.res;
      @(posedge clk);
      wait_done(1'b0, ExecLat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
